// File: rtl/sbox_sched_pkg.sv
// rtl/sbox_sched_pkg.sv - shared tags, limits and S-box mode encodings for sbox_sched
package sbox_sched_pkg;

  typedef enum logic {
    TAG_RD = 1'b0,
    TAG_KS = 1'b1
  } tag_e;

  localparam int   LAT_MAX  = 4;
  localparam logic SBOX_FWD = 1'b1;
  localparam logic SBOX_INV = 1'b0;

  // One in-flight record: occupied flag plus the owner of the op
  typedef struct packed {
    logic vld;
    tag_e tag;
  } trk_t;

endpackage

// File: rtl/sbox_sched_track.sv
// rtl/sbox_sched_track.sv - LAT-deep in-flight tracker, pass-through when LAT is 0
module sbox_sched_track
  import sbox_sched_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue_valid_i,
  input  tag_e issue_tag_i,
  output logic ret_valid_o,
  output tag_e ret_tag_o
);

  if (LAT == 0) begin : g_pass
    // Combinational array: the op retires in the cycle it issues
    assign ret_valid_o = issue_valid_i;
    assign ret_tag_o   = issue_tag_i;
  end else begin : g_pipe
    trk_t [LAT-1:0] pipe_q;

    // Advance every record one stage per cycle, mirroring the array pipeline
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe_q <= '0;
      end else begin
        for (int i = LAT - 1; i > 0; i--) begin
          pipe_q[i] <= pipe_q[i-1];
        end
        pipe_q[0] <= '{vld: issue_valid_i, tag: issue_tag_i};
      end
    end

    assign ret_valid_o = pipe_q[LAT-1].vld;
    assign ret_tag_o   = pipe_q[LAT-1].tag;
  end

endmodule

// File: rtl/sbox_sched.sv
// rtl/sbox_sched.sv - time-shares one S-box array between round and key-schedule requesters (option: SBOX_SCHED_KS_PRIO_EN)
module sbox_sched
  import sbox_sched_pkg::*;
#(
  parameter int LAT      = 1,
  parameter int KS_LANES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rd_req_valid,
  output logic                    rd_req_ready,
  input  logic [127:0]            rd_req_data,
  input  logic                    rd_req_mode,
  output logic                    rd_rsp_valid,
  input  logic                    rd_rsp_ready,
  output logic [127:0]            rd_rsp_data,
  input  logic                    ks_req_valid,
  output logic                    ks_req_ready,
  input  logic [8*KS_LANES-1:0]   ks_req_data,
  output logic                    ks_rsp_valid,
  input  logic                    ks_rsp_ready,
  output logic [8*KS_LANES-1:0]   ks_rsp_data,
  output logic [127:0]            sbox_in,
  output logic                    sbox_mode,
  input  logic [127:0]            sbox_out
);

  localparam int KS_W = 8 * KS_LANES;

  logic            rd_pend_q, rd_pend_d, ks_pend_q, ks_pend_d;
  logic            rd_vld_q, rd_vld_d, ks_vld_q, ks_vld_d;
  logic [127:0]    rd_dat_q, rd_dat_d;
  logic [KS_W-1:0] ks_dat_q, ks_dat_d;
  logic            rd_elig, ks_elig, rd_gnt, ks_gnt;
  logic            issue_valid, ret_valid;
  tag_e            issue_tag, ret_tag;
`ifndef SBOX_SCHED_KS_PRIO_EN
  tag_e            last_q, last_d;
`endif

  // Arbitration and array drive; nothing is eligible while reset is held
  always_comb begin
    rd_elig   = rst_n & rd_req_valid & ~rd_pend_q;
    ks_elig   = rst_n & ks_req_valid & ~ks_pend_q;
    rd_gnt    = 1'b0;
    ks_gnt    = 1'b0;
    sbox_in   = '0;
    sbox_mode = SBOX_FWD;
    if (rd_elig && ks_elig) begin
`ifdef SBOX_SCHED_KS_PRIO_EN
      ks_gnt = 1'b1;
`else
      if (last_q == TAG_KS) rd_gnt = 1'b1;
      else                  ks_gnt = 1'b1;
`endif
    end else begin
      rd_gnt = rd_elig;
      ks_gnt = ks_elig;
    end
    if (rd_gnt) begin
      sbox_in   = rd_req_data;
      sbox_mode = rd_req_mode;
    end else if (ks_gnt) begin
      sbox_in   = {{(128-KS_W){1'b0}}, ks_req_data};
    end
    issue_valid = rd_gnt | ks_gnt;
    issue_tag   = ks_gnt ? TAG_KS : TAG_RD;
  end

  assign rd_req_ready = rd_gnt;
  assign ks_req_ready = ks_gnt;

  sbox_sched_track #(.LAT(LAT)) u_track (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid_i (issue_valid),
    .issue_tag_i   (issue_tag),
    .ret_valid_o   (ret_valid),
    .ret_tag_o     (ret_tag)
  );

  // Next state: pending flags, response holding registers, round-robin pointer
  always_comb begin
    rd_pend_d = rd_pend_q;
    ks_pend_d = ks_pend_q;
    rd_vld_d  = rd_vld_q;
    ks_vld_d  = ks_vld_q;
    rd_dat_d  = rd_dat_q;
    ks_dat_d  = ks_dat_q;
    if (rd_gnt)                      rd_pend_d = 1'b1;
    else if (rd_vld_q && rd_rsp_ready) rd_pend_d = 1'b0;
    if (ks_gnt)                      ks_pend_d = 1'b1;
    else if (ks_vld_q && ks_rsp_ready) ks_pend_d = 1'b0;
    if (ret_valid && ret_tag == TAG_RD) begin
      rd_vld_d = 1'b1;
      rd_dat_d = sbox_out;
    end else if (rd_vld_q && rd_rsp_ready) begin
      rd_vld_d = 1'b0;
    end
    if (ret_valid && ret_tag == TAG_KS) begin
      ks_vld_d = 1'b1;
      ks_dat_d = sbox_out[KS_W-1:0];
    end else if (ks_vld_q && ks_rsp_ready) begin
      ks_vld_d = 1'b0;
    end
`ifndef SBOX_SCHED_KS_PRIO_EN
    last_d = last_q;
    if (issue_valid) last_d = issue_tag;
`endif
  end

  // State registers; reset drops every in-flight op and pending response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q <= 1'b0;
      ks_pend_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      ks_vld_q  <= 1'b0;
      rd_dat_q  <= '0;
      ks_dat_q  <= '0;
`ifndef SBOX_SCHED_KS_PRIO_EN
      last_q    <= TAG_KS;
`endif
    end else begin
      rd_pend_q <= rd_pend_d;
      ks_pend_q <= ks_pend_d;
      rd_vld_q  <= rd_vld_d;
      ks_vld_q  <= ks_vld_d;
      rd_dat_q  <= rd_dat_d;
      ks_dat_q  <= ks_dat_d;
`ifndef SBOX_SCHED_KS_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

  assign rd_rsp_valid = rd_vld_q;
  assign rd_rsp_data  = rd_dat_q;
  assign ks_rsp_valid = ks_vld_q;
  assign ks_rsp_data  = ks_dat_q;

endmodule

// File: tb/tb_sbox_sched.sv
// tb/tb_sbox_sched.sv - directed table-driven bench for sbox_sched
module tb_sbox_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         rd_req_valid, rd_req_ready, rd_req_mode, rd_rsp_valid, rd_rsp_ready;
  logic [127:0] rd_req_data, rd_rsp_data, sbox_in, sbox_out;
  logic         ks_req_valid, ks_req_ready, ks_rsp_valid, ks_rsp_ready, sbox_mode;
  logic [31:0]  ks_req_data, ks_rsp_data;

  logic         b_rd_req_valid, b_rd_req_ready, b_rd_rsp_valid;
  logic         b_ks_req_valid, b_ks_req_ready, b_ks_rsp_valid, b_sbox_mode;
  logic [127:0] b_rd_rsp_data, b_sbox_in, b_sbox_out;
  logic [31:0]  b_ks_rsp_data;

  sbox_sched #(.LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_data(rd_req_data),
    .rd_req_mode(rd_req_mode), .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
    .rd_rsp_data(rd_rsp_data), .ks_req_valid(ks_req_valid), .ks_req_ready(ks_req_ready),
    .ks_req_data(ks_req_data), .ks_rsp_valid(ks_rsp_valid), .ks_rsp_ready(ks_rsp_ready),
    .ks_rsp_data(ks_rsp_data), .sbox_in(sbox_in), .sbox_mode(sbox_mode), .sbox_out(sbox_out)
  );

  sbox_sched #(.LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .rd_req_valid(b_rd_req_valid), .rd_req_ready(b_rd_req_ready), .rd_req_data(rd_req_data),
    .rd_req_mode(rd_req_mode), .rd_rsp_valid(b_rd_rsp_valid), .rd_rsp_ready(1'b1),
    .rd_rsp_data(b_rd_rsp_data), .ks_req_valid(b_ks_req_valid), .ks_req_ready(b_ks_req_ready),
    .ks_req_data(ks_req_data), .ks_rsp_valid(b_ks_rsp_valid), .ks_rsp_ready(1'b1),
    .ks_rsp_data(b_ks_rsp_data), .sbox_in(b_sbox_in), .sbox_mode(b_sbox_mode), .sbox_out(b_sbox_out)
  );

  // AES S-box tables built from GF(2^8) inversion plus the affine map
  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] arr(input logic [127:0] x, input logic m);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = m ? fwd_t[x[8*i +: 8]] : inv_t[x[8*i +: 8]];
    return r;
  endfunction

  initial begin
    logic [7:0] v, s;
    for (int x = 0; x < 256; x++) begin
      v = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      s = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
      fwd_t[x] = s;
      inv_t[s] = 8'(x);
    end
  end

  // Array models: 1-stage for the main instance, 3-stage for the flush instance
  logic [127:0] a1_q, b1_q, b2_q, b3_q;
  always_ff @(posedge clk) begin
    a1_q <= arr(sbox_in, sbox_mode);
    b1_q <= arr(b_sbox_in, b_sbox_mode);
    b2_q <= b1_q;
    b3_q <= b2_q;
  end
  assign sbox_out   = a1_q;
  assign b_sbox_out = b3_q;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request through the main instance; returns result and cycles from handshake to rsp_valid
  task automatic run_req(input bit ks, input logic [127:0] d, input logic m,
                         output logic [127:0] got, output int lat);
    int n;
    rd_rsp_ready = 1'b1;
    ks_rsp_ready = 1'b1;
    if (ks) begin
      ks_req_data = d[31:0]; ks_req_valid = 1'b1;
    end else begin
      rd_req_data = d; rd_req_mode = m; rd_req_valid = 1'b1;
    end
    #1;
    n = 0;
    while (!(ks ? ks_req_ready : rd_req_ready) && n < 20) begin tick(); #1; n++; end
    chkb("req_ready", ks ? ks_req_ready : rd_req_ready, 1'b1);
    chk("issue_sbox_in", sbox_in, ks ? {96'b0, d[31:0]} : d);
    chkb("issue_sbox_mode", sbox_mode, ks ? 1'b1 : m);
    tick();
    rd_req_valid = 1'b0;
    ks_req_valid = 1'b0;
    #1;
    lat = 1;
    while (!(ks ? ks_rsp_valid : rd_rsp_valid) && lat < 20) begin tick(); #1; lat++; end
    got = ks ? {96'b0, ks_rsp_data} : rd_rsp_data;
    tick();
  endtask

  typedef struct {
    logic [127:0] d;
    logic         m;
    logic [127:0] e;
  } vec_t;

  vec_t vt [6];

  initial begin
    logic [127:0] got;
    logic [31:0]  ks_got;
    int           lat, n, g[$], exp_first[4];
    logic         both, ksg, ks_seen, first_rd, seen;

    vt[0] = '{{16{8'h00}}, 1'b1, {16{8'h63}}};
    vt[1] = '{{{15{8'h00}}, 8'h63}, 1'b0, {{15{8'h52}}, 8'h00}};
    vt[2] = '{{{15{8'h00}}, 8'h53}, 1'b1, {{15{8'h63}}, 8'hed}};
    vt[3] = '{{16{8'h01}}, 1'b1, {16{8'h7c}}};
    vt[4] = '{{16{8'hed}}, 1'b0, {16{8'h53}}};
    vt[5] = '{128'h0f0e0d0c0b0a09080706050403020100, 1'b1, 128'h76abd7fe2b670130c56f6bf27b777c63};
`ifdef SBOX_SCHED_KS_PRIO_EN
    exp_first = '{1, 0, 1, 0};
`else
    exp_first = '{0, 1, 0, 1};
`endif

    rst_n = 1'b0;
    rd_req_valid = 1'b1; ks_req_valid = 1'b1; rd_req_mode = 1'b1;
    rd_req_data = {16{8'h11}}; ks_req_data = 32'h22222222;
    rd_rsp_ready = 1'b1; ks_rsp_ready = 1'b1;
    b_rd_req_valid = 1'b0; b_ks_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chkb("rst_rd_req_ready", rd_req_ready, 1'b0);
    chkb("rst_ks_req_ready", ks_req_ready, 1'b0);
    chkb("rst_rd_rsp_valid", rd_rsp_valid, 1'b0);
    chkb("rst_ks_rsp_valid", ks_rsp_valid, 1'b0);
    chk("rst_rd_rsp_data", rd_rsp_data, '0);
    chk("rst_ks_rsp_data", {96'b0, ks_rsp_data}, '0);
    chk("rst_sbox_in", sbox_in, '0);
    chkb("rst_sbox_mode", sbox_mode, 1'b1);
    rd_req_valid = 1'b0; ks_req_valid = 1'b0;
    tick(); rst_n = 1'b1; tick(); tick();

    for (int i = 0; i < 6; i++) begin
      run_req(1'b0, vt[i].d, vt[i].m, got, lat);
      chk("rd_vec_data", got, vt[i].e);
      chki("rd_vec_latency", lat, 2);
    end

    run_req(1'b1, {96'b0, 32'hcf4f3c09}, 1'b0, got, lat);
    chk("ks_subword", got, {96'b0, 32'h8a84eb01});
    chki("ks_latency", lat, 2);

    // Both requesters valid continuously
    rd_req_data = {16{8'h00}}; rd_req_mode = 1'b1; ks_req_data = 32'h0;
    rd_req_valid = 1'b1; ks_req_valid = 1'b1; both = 1'b0;
    #1;
    for (int c = 0; c < 13; c++) begin
      if (rd_req_ready && ks_req_ready) both = 1'b1;
      if (rd_req_ready) g.push_back(0);
      if (ks_req_ready) g.push_back(1);
      tick(); #1;
    end
    rd_req_valid = 1'b0; ks_req_valid = 1'b0;
    chkb("arb_single_grant", both, 1'b0);
    chki("arb_grant_count", g.size(), 9);
    for (int i = 0; i < 4; i++) chki("arb_order", (i < g.size()) ? g[i] : -1, exp_first[i]);
    repeat (8) tick();

    // Fresh conflict after the alternating run: KS wins in either arbitration mode
    rd_req_valid = 1'b1; ks_req_valid = 1'b1; #1;
    chkb("conflict2_ks_ready", ks_req_ready, 1'b1);
    chkb("conflict2_rd_ready", rd_req_ready, 1'b0);
    tick(); #1;
    chkb("conflict2_rd_next", rd_req_ready, 1'b1);
    tick(); rd_req_valid = 1'b0; ks_req_valid = 1'b0;
    repeat (8) tick();

    // Round response backpressure while key-schedule traffic continues
    rd_rsp_ready = 1'b0; ks_rsp_ready = 1'b1;
    rd_req_data = {16{8'h53}}; rd_req_mode = 1'b1; rd_req_valid = 1'b1; #1;
    chkb("bp_issue_ready", rd_req_ready, 1'b1);
    tick(); rd_req_data = {16{8'h00}}; #1;
    n = 0;
    while (!rd_rsp_valid && n < 20) begin tick(); #1; n++; end
    chk("bp_first_data", rd_rsp_data, {16{8'hed}});
    ks_req_data = 32'h0; ks_req_valid = 1'b1; #1;
    ksg = 1'b0; ks_seen = 1'b0; ks_got = '0;
    for (int i = 0; i < 5; i++) begin
      chkb("bp_rsp_valid_held", rd_rsp_valid, 1'b1);
      chk("bp_rsp_data_stable", rd_rsp_data, {16{8'hed}});
      chkb("bp_rd_req_blocked", rd_req_ready, 1'b0);
      if (ks_req_ready) ksg = 1'b1;
      if (ks_rsp_valid) begin ks_seen = 1'b1; ks_got = ks_rsp_data; end
      tick();
      if (ksg) ks_req_valid = 1'b0;
      #1;
    end
    chkb("bp_ks_flowed", ks_seen, 1'b1);
    chk("bp_ks_data", {96'b0, ks_got}, {96'b0, 32'h63636363});
    rd_rsp_ready = 1'b1; #1;
    chkb("bp_blocked_at_release", rd_req_ready, 1'b0);
    tick(); #1;
    chkb("bp_regrant_next_cycle", rd_req_ready, 1'b1);
    chkb("bp_rsp_cleared", rd_rsp_valid, 1'b0);
    tick(); rd_req_valid = 1'b0; #1;
    n = 0;
    while (!rd_rsp_valid && n < 20) begin tick(); #1; n++; end
    chk("bp_second_data", rd_rsp_data, {16{8'h63}});
    tick(); tick();

    // LAT=3 instance: two ops in flight, then reset
    rd_req_data = {16{8'h00}}; rd_req_mode = 1'b1; ks_req_data = 32'h0;
    b_rd_req_valid = 1'b1; b_ks_req_valid = 1'b1; #1;
    chkb("flush_one_grant", b_rd_req_ready ^ b_ks_req_ready, 1'b1);
    first_rd = b_rd_req_ready;
    tick();
    if (first_rd) b_rd_req_valid = 1'b0; else b_ks_req_valid = 1'b0;
    #1;
    chkb("flush_second_grant", first_rd ? b_ks_req_ready : b_rd_req_ready, 1'b1);
    tick();
    b_rd_req_valid = 1'b0; b_ks_req_valid = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (b_rd_rsp_valid || b_ks_rsp_valid) seen = 1'b1;
      tick();
    end
    chkb("flush_no_response", seen, 1'b0);
    rd_req_data = {16{8'h53}}; b_rd_req_valid = 1'b1; #1;
    chkb("post_rst_ready", b_rd_req_ready, 1'b1);
    tick(); b_rd_req_valid = 1'b0; #1;
    lat = 1;
    while (!b_rd_rsp_valid && lat < 20) begin tick(); #1; lat++; end
    chki("post_rst_latency", lat, 4);
    chk("post_rst_data", b_rd_rsp_data, {16{8'hed}});
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
